// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring, MIPS semantics) unit holding HI/LO.
// Optional macro MULTDIV_DIVZERO_DETECT_EN: divide by zero exits after one cycle with a div_zero pulse.
module mult_div_unit #(
  parameter int N_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic [32:0] r_acc;
  logic [31:0] r_q;
  logic        r_qm1;
  logic [31:0] r_m;
  logic        r_negQ;
  logic        r_negR;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [32:0] w_boothSum;
  logic [32:0] w_multAcc;
  logic [31:0] w_multQ;
  logic [32:0] w_divShift;
  logic [32:0] w_divDiff;
  logic        w_divBit;
  logic [32:0] w_divRem;
  logic [31:0] w_divQuo;
  logic        w_last;
  logic        w_divZeroHit;
  logic        w_finishing;
  logic        w_canStart;

  assign w_absA = A[31] ? -A : A;
  assign w_absB = B[31] ? -B : B;
  assign w_last = (r_count == 5'(N_ITER - 1));

  // Accumulator is 33 bits so that subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    w_boothSum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_boothSum = r_acc + {r_m[31], r_m};
      2'b10:   w_boothSum = r_acc - {r_m[31], r_m};
      default: w_boothSum = r_acc;
    endcase
  end

  assign w_multAcc  = {w_boothSum[32], w_boothSum[32:1]};
  assign w_multQ    = {w_boothSum[0], r_q[31:1]};

  assign w_divShift = {r_acc[31:0], r_q[31]};
  assign w_divDiff  = w_divShift - {1'b0, r_m};
  assign w_divBit   = ~w_divDiff[32];
  assign w_divRem   = w_divBit ? w_divDiff : w_divShift;
  assign w_divQuo   = {r_q[30:0], w_divBit};

`ifdef MULTDIV_DIVZERO_DETECT_EN
  logic r_divZero;
  assign w_divZeroHit = (r_m == 32'd0);
  assign div_zero     = r_divZero;
`else
  assign w_divZeroHit = 1'b0;
  assign div_zero     = 1'b0;
`endif

  // A new start is accepted in IDLE and also on the edge that completes an operation.
  assign w_finishing = ((r_state == S_MULT) && w_last) ||
                       ((r_state == S_DIV) && (w_last || w_divZeroHit));
  assign w_canStart  = (r_state == S_IDLE) || w_finishing;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_m       <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MULTDIV_DIVZERO_DETECT_EN
      r_divZero <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
`ifdef MULTDIV_DIVZERO_DETECT_EN
      r_divZero <= 1'b0;
`endif
      case (r_state)
        S_MULT: begin
          r_acc   <= w_multAcc;
          r_q     <= w_multQ;
          r_qm1   <= r_q[0];
          r_count <= r_count + 5'd1;
          if (w_last) begin
            r_hi    <= w_multAcc[31:0];
            r_lo    <= w_multQ;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_DIV: begin
          if (w_divZeroHit) begin
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
`ifdef MULTDIV_DIVZERO_DETECT_EN
            r_divZero <= 1'b1;
`endif
          end else begin
            r_acc   <= w_divRem;
            r_q     <= w_divQuo;
            r_count <= r_count + 5'd1;
            if (w_last) begin
              r_hi    <= r_negR ? -w_divRem[31:0] : w_divRem[31:0];
              r_lo    <= r_negQ ? -w_divQuo : w_divQuo;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Placed after the case so a start on a done edge overrides the return to IDLE.
      if (w_canStart) begin
        if (mult_start) begin
          r_acc   <= '0;
          r_q     <= B;
          r_qm1   <= 1'b0;
          r_m     <= A;
          r_count <= '0;
          r_busy  <= 1'b1;
          r_state <= S_MULT;
        end else if (div_start) begin
          r_acc   <= '0;
          r_q     <= w_absA;
          r_qm1   <= 1'b0;
          r_m     <= w_absB;
          r_negQ  <= A[31] ^ B[31];
          r_negR  <= A[31];
          r_count <= '0;
          r_busy  <= 1'b1;
          r_state <= S_DIV;
        end
      end
    end
  end

  assign HI_out = r_hi;
  assign LO_out = r_lo;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
